// File: rtl/pc_seq.sv
// Program counter sequencer with INC/JMP/BR/CALL/RET and a return-address stack.
// Bad CALL/RET (stack full/empty) degrade to INC and raise a sticky err flag.
module pc_seq #(
  parameter int unsigned PC_WIDTH     = 8,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned OFF_WIDTH    = 4,
  parameter int unsigned STACK_DEPTH  = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 en,
  input  logic [2:0]                           op,
  input  logic [PC_WIDTH-1:0]                  target,
  input  logic [OFF_WIDTH-1:0]                 offset,
  input  logic                                 cond,
  output logic [PC_WIDTH-1:0]                  pc,
  output logic [$clog2(STACK_DEPTH+1)-1:0]     sp,
  output logic                                 stack_full,
  output logic                                 stack_empty,
  output logic                                 err
);

  localparam int unsigned SPW  = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDXW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [2:0] OP_JMP  = 3'b001;
  localparam logic [2:0] OP_BR   = 3'b010;
  localparam logic [2:0] OP_CALL = 3'b011;
  localparam logic [2:0] OP_RET  = 3'b100;

  logic [PC_WIDTH-1:0] stack [STACK_DEPTH];

  logic [PC_WIDTH-1:0] pc_next;
  logic [SPW-1:0]      sp_next;
  logic                err_next;
  logic                push;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] off_ext;
  logic [IDXW-1:0]     top_idx;
  logic [IDXW-1:0]     push_idx;

  assign pc_inc   = pc + PC_WIDTH'(1);
  assign off_ext  = PC_WIDTH'($signed(offset));
  assign top_idx  = IDXW'(sp - SPW'(1));
  assign push_idx = IDXW'(sp);

  assign stack_full  = (sp == SPW'(STACK_DEPTH));
  assign stack_empty = (sp == '0);

  always_comb begin
    pc_next  = pc_inc;
    sp_next  = sp;
    err_next = err;
    push     = 1'b0;
    case (op)
      OP_JMP: pc_next = target;
      OP_BR: begin
        if (cond) pc_next = pc + off_ext;
      end
      OP_CALL: begin
        if (!stack_full) begin
          push    = 1'b1;
          pc_next = target;
          sp_next = sp + SPW'(1);
        end else begin
          err_next = 1'b1;
        end
      end
      OP_RET: begin
        if (!stack_empty) begin
          pc_next = stack[top_idx];
          sp_next = sp - SPW'(1);
        end else begin
          err_next = 1'b1;
        end
      end
      default: ;  // INC, including the unused encodings
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc  <= RESET_VECTOR;
      sp  <= '0;
      err <= 1'b0;
    end else if (en) begin
      pc  <= pc_next;
      sp  <= sp_next;
      err <= err_next;
    end
  end

  // Stack storage has no reset: entries above sp are never read.
  always_ff @(posedge clk) begin
    if (en && push && !reset) stack[push_idx] <= pc_inc;
  end

endmodule

// File: tb/tb_pc_seq.sv
// Randomized and directed bench for pc_seq against a queue-based reference model.
module tb_pc_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [2:0] op;
  logic [7:0] target;
  logic [3:0] offset;
  logic       cond;
  logic [7:0] pc;
  logic [2:0] sp;
  logic       stack_full;
  logic       stack_empty;
  logic       err;

  int n_cmp = 0;
  int n_mis = 0;

  // reference model state
  int m_pc;
  int m_err;
  int m_stack[$];

  pc_seq #(
    .PC_WIDTH(8), .RESET_VECTOR(8'h10), .OFF_WIDTH(4), .STACK_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .op(op), .target(target),
    .offset(offset), .cond(cond), .pc(pc), .sp(sp),
    .stack_full(stack_full), .stack_empty(stack_empty), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_pc"}, 32'(pc), 32'(m_pc));
    check({tag, "_sp"}, 32'(sp), 32'(m_stack.size()));
    check({tag, "_full"}, 32'(stack_full), 32'(m_stack.size() == 4));
    check({tag, "_empty"}, 32'(stack_empty), 32'(m_stack.size() == 0));
    check({tag, "_err"}, 32'(err), 32'(m_err));
  endtask

  function automatic void model_reset();
    m_pc  = 'h10;
    m_err = 0;
    m_stack.delete();
  endfunction

  function automatic void model_step(input int e, input int o, input int t, input int off, input int c);
    int nxt;
    if (!e) return;
    nxt = (m_pc + 1) % 256;
    case (o)
      1: nxt = t;
      2: if (c) nxt = (m_pc + ((off >= 8) ? off - 16 : off) + 256) % 256;
      3: if (m_stack.size() < 4) begin
           m_stack.push_back((m_pc + 1) % 256);
           nxt = t;
         end else m_err = 1;
      4: if (m_stack.size() > 0) nxt = m_stack.pop_back();
         else m_err = 1;
      default: ;
    endcase
    m_pc = nxt;
  endfunction

  // Called just after a rising edge; drives one op, clocks it, checks 1 ns after the edge.
  task automatic exec(input string tag, input logic e, input logic [2:0] o,
                      input logic [7:0] t, input logic [3:0] off, input logic c);
    en = e; op = o; target = t; offset = off; cond = c;
    @(posedge clk);
    model_step(int'(e), int'(o), int'(t), int'(off), int'(c));
    #1;
    check_all(tag);
    $display("op=%0d en=%0b tgt=%02h off=%0h cond=%0b -> pc=%02h sp=%0d err=%0b",
             o, e, t, off, c, pc, sp, err);
  endtask

  // Reset asserted mid-cycle; outputs checked before the next edge.
  task automatic async_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1;
    check_all(tag);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; op = '0; target = '0; offset = '0; cond = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("por");
    reset = 1'b0;

    // build pc=0x25, sp=2 with err set, then reset between edges
    exec("ret_empty0", 1, 3'd4, 8'h00, 4'h0, 0);
    exec("call_a", 1, 3'd3, 8'h30, 4'h0, 0);
    exec("call_b", 1, 3'd3, 8'h24, 4'h0, 0);
    exec("inc_25", 1, 3'd0, 8'h00, 4'h0, 0);
    check("pre_rst_pc", 32'(pc), 32'h25);
    async_reset("mid_rst");
    exec("inc1", 1, 3'd0, 8'h00, 4'h0, 0);
    exec("inc2", 1, 3'd0, 8'h00, 4'h0, 0);
    check("after_rst_pc", 32'(pc), 32'h12);

    // wraps and branches
    exec("jmp_ff", 1, 3'd1, 8'hFF, 4'h0, 0);
    exec("inc_wrap", 1, 3'd0, 8'h00, 4'h0, 0);
    check("wrap_pc", 32'(pc), 32'h00);
    exec("inc_01", 1, 3'd0, 8'h00, 4'h0, 0);
    exec("br_neg", 1, 3'd2, 8'h00, 4'hE, 1);
    check("br_neg_pc", 32'(pc), 32'hFF);
    exec("jmp_01", 1, 3'd1, 8'h01, 4'h0, 0);
    exec("br_nt", 1, 3'd2, 8'h00, 4'hE, 0);
    check("br_nt_pc", 32'(pc), 32'h02);

    // stall with a pending JMP, stack nonempty
    exec("call_st", 1, 3'd3, 8'h50, 4'h0, 0);
    for (int i = 0; i < 3; i++) exec("stall", 0, 3'd1, 8'h80, 4'h0, 0);
    check("stall_pc", 32'(pc), 32'h50);

    // nested call/return
    async_reset("rst2");
    exec("call40", 1, 3'd3, 8'h40, 4'h0, 0);
    exec("call60", 1, 3'd3, 8'h60, 4'h0, 0);
    check("call60_sp", 32'(sp), 32'd2);
    exec("ret1", 1, 3'd4, 8'h00, 4'h0, 0);
    check("ret1_pc", 32'(pc), 32'h41);
    exec("ret2", 1, 3'd4, 8'h00, 4'h0, 0);
    check("ret2_pc", 32'(pc), 32'h11);

    // overflow
    for (int i = 0; i < 5; i++) exec("call_ovf", 1, 3'd3, 8'(8'h20 + 8'(i * 16)), 4'h0, 0);
    check("ovf_pc", 32'(pc), 32'h51);
    check("ovf_err", 32'(err), 32'd1);
    exec("ret_ovf", 1, 3'd4, 8'h00, 4'h0, 0);
    check("ret_ovf_pc", 32'(pc), 32'h41);

    // underflow and unused opcode
    async_reset("rst3");
    exec("jmp30", 1, 3'd1, 8'h30, 4'h0, 0);
    exec("ret_unf", 1, 3'd4, 8'h00, 4'h0, 0);
    check("unf_pc", 32'(pc), 32'h31);
    exec("op7", 1, 3'd7, 8'h99, 4'h5, 1);
    check("op7_pc", 32'(pc), 32'h32);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if (i % 150 == 149) async_reset("rnd_rst");
      exec("rnd", 1'($urandom_range(0, 9) != 0), 3'($urandom_range(0, 7)),
           8'($urandom), 4'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
